// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the fetch sequencing controller: state and redirect-kind encodings.
// FC_ADDR_W is the project-wide instruction address width.
package fetch_ctrl_pkg;

    localparam int FC_ADDR_W = 32;

    typedef enum logic [1:0] {
        FC_IDLE = 2'd0,
        FC_RUN  = 2'd1,
        FC_HALT = 2'd2
    } fc_state_e;

    typedef enum logic [1:0] {
        RK_NONE = 2'd0,
        RK_BR   = 2'd1,
        RK_TRAP = 2'd2
    } redir_kind_e;

    // A trap always beats a branch raised in the same cycle.
    function automatic redir_kind_e fc_req_kind(input logic trap_v, input logic br_v);
        if (trap_v) return RK_TRAP;
        if (br_v)   return RK_BR;
        return RK_NONE;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle of redirect/stall requests into the controller and its fetch-facing outputs.
// master = controller side, slave = pipeline/environment side.
interface fetch_ctrl_if #(
    parameter int ADDR_W = fetch_ctrl_pkg::FC_ADDR_W
);
    logic              start_i;
    logic              halt_i;
    logic              dec_stall_i;
    logic              imem_rdy_i;
    logic              br_v_i;
    logic [ADDR_W-1:0] br_addr_i;
    logic              trap_v_i;
    logic [ADDR_W-1:0] trap_addr_i;
    logic              stall_o;
    logic              branch_o;
    logic [ADDR_W-1:0] baddr_o;
    logic              flush_o;
    logic              running_o;

    modport master (
        input  start_i, halt_i, dec_stall_i, imem_rdy_i,
        input  br_v_i, br_addr_i, trap_v_i, trap_addr_i,
        output stall_o, branch_o, baddr_o, flush_o, running_o
    );

    modport slave (
        output start_i, halt_i, dec_stall_i, imem_rdy_i,
        output br_v_i, br_addr_i, trap_v_i, trap_addr_i,
        input  stall_o, branch_o, baddr_o, flush_o, running_o
    );
endinterface

// File: rtl/fetch_redir_pend.sv
// One-entry pending-redirect register. A trap overwrites anything; a branch
// never displaces a still-valid pending trap.
module fetch_redir_pend #(
    parameter int ADDR_W = fetch_ctrl_pkg::FC_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              wr_i,
    input  logic              wr_trap_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    output logic              pend_v_o,
    output logic              pend_trap_o,
    output logic [ADDR_W-1:0] pend_addr_o
);
    logic              pend_v_q, pend_v_d;
    logic              pend_trap_q, pend_trap_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              keep_v;

    // Entry survives this cycle only if it is not being consumed.
    assign keep_v = pend_v_q & ~clr_i;

    always_comb begin
        pend_v_d    = keep_v;
        pend_trap_d = pend_trap_q;
        pend_addr_d = pend_addr_q;
        if (wr_i && (wr_trap_i || !keep_v || !pend_trap_q)) begin
            pend_v_d    = 1'b1;
            pend_trap_d = wr_trap_i;
            pend_addr_d = wr_addr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_v_q    <= 1'b0;
            pend_trap_q <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            pend_v_q    <= pend_v_d;
            pend_trap_q <= pend_trap_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    assign pend_v_o    = pend_v_q;
    assign pend_trap_o = pend_trap_q;
    assign pend_addr_o = pend_addr_q;
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: run/halt FSM, redirect arbitration and stall merging.
// Optional perf counters (stall_cnt_o, redir_cnt_o) are built when FETCH_CTRL_PERF_EN is defined.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int              ADDR_W  = FC_ADDR_W,
    parameter logic [ADDR_W-1:0] RST_VEC = '0
) (
    input  logic        clk,
    input  logic        rst,
    fetch_ctrl_if.master bus
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] redir_cnt_o
`endif
);
    fc_state_e         state_q, state_d;
    logic              first_q, first_d;
    redir_kind_e       req_kind;
    logic              has_req;
    logic              in_run;
    logic              issue;
    logic              pend_v, pend_trap;
    logic [ADDR_W-1:0] pend_addr;
    logic              pend_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] target;

    assign req_kind = fc_req_kind(bus.trap_v_i, bus.br_v_i);
    assign has_req  = (req_kind != RK_NONE);
    assign req_addr = (req_kind == RK_TRAP) ? bus.trap_addr_i : bus.br_addr_i;
    assign in_run   = (state_q == FC_RUN);
    assign issue    = in_run & (pend_v | first_q | has_req);

    // In RUN only a live branch that loses to the pending entry needs storing;
    // outside RUN every request is captured for the first RUN cycle.
    assign pend_wr = in_run ? (pend_v & (req_kind == RK_BR)) : has_req;

    fetch_redir_pend #(.ADDR_W(ADDR_W)) u_pend (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (issue),
        .wr_i        (pend_wr),
        .wr_trap_i   (req_kind == RK_TRAP),
        .wr_addr_i   (req_addr),
        .pend_v_o    (pend_v),
        .pend_trap_o (pend_trap),
        .pend_addr_o (pend_addr)
    );

    always_comb begin
        target = RST_VEC;
        if (req_kind == RK_TRAP) target = bus.trap_addr_i;
        else if (pend_v)         target = pend_addr;
        else if (req_kind == RK_BR) target = bus.br_addr_i;
    end

    always_comb begin
        state_d      = state_q;
        first_d      = first_q;
        bus.stall_o  = 1'b1;
        bus.branch_o = 1'b0;
        bus.baddr_o  = '0;
        bus.flush_o  = 1'b0;
        case (state_q)
            FC_IDLE: begin
                if (bus.start_i) begin
                    state_d = FC_RUN;
                    first_d = 1'b1;
                end
            end
            FC_RUN: begin
                if (issue) begin
                    bus.stall_o  = 1'b0;
                    bus.branch_o = 1'b1;
                    bus.baddr_o  = target;
                    bus.flush_o  = 1'b1;
                    first_d      = 1'b0;
                end else begin
                    bus.stall_o = bus.dec_stall_i | ~bus.imem_rdy_i;
                end
                if (bus.halt_i) state_d = FC_HALT;
            end
            FC_HALT: begin
                if (bus.start_i) state_d = FC_RUN;
            end
            default: state_d = FC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FC_IDLE;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
        end
    end

    assign bus.running_o = in_run;

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] redir_cnt_q, redir_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        redir_cnt_d = redir_cnt_q;
        if (in_run && bus.stall_o && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (bus.branch_o && redir_cnt_q != 32'hFFFF_FFFF)
            redir_cnt_d = redir_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign redir_cnt_o = redir_cnt_q;
`else
    // pend_trap only steers the overwrite rule inside the pending register.
    logic unused_pend_trap;
    assign unused_pend_trap = pend_trap;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized traffic
// against a behavioural model of the run/halt and redirect rules.
module tb_fetch_ctrl;
    localparam logic [31:0] RV = 32'h40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_ctrl_if #(.ADDR_W(32)) bus ();
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] stall_cnt, redir_cnt;
`endif

    fetch_ctrl #(.ADDR_W(32), .RST_VEC(RV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FETCH_CTRL_PERF_EN
        ,
        .stall_cnt_o (stall_cnt),
        .redir_cnt_o (redir_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Model: 0 = idle, 1 = running, 2 = halted
    int          m_mode  = 0;
    bit          m_first = 0;
    bit          m_pv = 0, m_pt = 0;
    logic [31:0] m_pa = '0;
    int unsigned m_scnt = 0, m_rcnt = 0;
    logic        e_stall, e_branch, e_flush, e_run;
    logic [31:0] e_addr;

    task automatic model_out();
        bit go;
        go = (m_mode == 1) && (m_pv || m_first || bus.trap_v_i || bus.br_v_i);
        e_run = (m_mode == 1);
        e_branch = go; e_flush = go; e_addr = '0;
        if (go) begin
            e_stall = 0;
            if (bus.trap_v_i) e_addr = bus.trap_addr_i;
            else if (m_pv)    e_addr = m_pa;
            else if (bus.br_v_i) e_addr = bus.br_addr_i;
            else e_addr = RV;
        end else if (m_mode == 1) e_stall = bus.dec_stall_i | ~bus.imem_rdy_i;
        else e_stall = 1;
    endtask

    task automatic tick();
        model_out();
        if (rst) begin
            m_mode = 0; m_first = 0; m_pv = 0; m_pt = 0; m_pa = '0; m_scnt = 0; m_rcnt = 0;
        end else if (m_mode == 1) begin
            if (e_run && e_stall) m_scnt++;
            if (e_branch) m_rcnt++;
            if (e_branch) begin
                // a live branch beaten by the pending entry becomes the new pending entry
                if (!bus.trap_v_i && bus.br_v_i && m_pv) begin
                    m_pv = 1; m_pt = 0; m_pa = bus.br_addr_i;
                end else m_pv = 0;
                m_first = 0;
            end
            if (bus.halt_i) m_mode = 2;
        end else begin
            if (bus.trap_v_i) begin
                m_pv = 1; m_pt = 1; m_pa = bus.trap_addr_i;
            end else if (bus.br_v_i && !(m_pv && m_pt)) begin
                m_pv = 1; m_pt = 0; m_pa = bus.br_addr_i;
            end
            if (bus.start_i) begin
                if (m_mode == 0) m_first = 1;
                m_mode = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit rs, input bit st, input bit hl, input bit ds, input bit rdy,
                          input bit bv, input logic [31:0] ba, input bit tv, input logic [31:0] ta);
        rst = rs;
        bus.start_i = st; bus.halt_i = hl; bus.dec_stall_i = ds; bus.imem_rdy_i = rdy;
        bus.br_v_i = bv; bus.br_addr_i = ba; bus.trap_v_i = tv; bus.trap_addr_i = ta;
        #2;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            set_in(1, 0, 0, 0, 1, 0, 0, 0, 0);
            tick();
            #2;
            total++;
            if ({bus.stall_o, bus.branch_o, bus.flush_o, bus.running_o} !== 4'b1000 || bus.baddr_o !== 32'h0) begin
                bad++;
                $display("FAIL reset%0d: stall/branch/flush/run=%b%b%b%b baddr=%h, want 1000 baddr=0", i,
                         bus.stall_o, bus.branch_o, bus.flush_o, bus.running_o, bus.baddr_o);
            end
        end
        $display("test_reset checked");
    endtask

    task automatic test_first_fetch();
        set_in(0, 1, 0, 0, 1, 0, 0, 0, 0);
        total++;
        if (bus.stall_o !== 1'b1 || bus.running_o !== 1'b0) begin
            bad++; $display("FAIL idle_start: stall=%b run=%b want 1 0", bus.stall_o, bus.running_o);
        end
        tick();
        set_in(0, 0, 0, 0, 1, 0, 0, 0, 0);
        total++;
        if ({bus.branch_o, bus.flush_o, bus.stall_o} !== 3'b110 || bus.baddr_o !== RV) begin
            bad++; $display("FAIL first_run: branch/flush/stall=%b%b%b baddr=%h want 110 %h",
                            bus.branch_o, bus.flush_o, bus.stall_o, bus.baddr_o, RV);
        end
        tick();
        set_in(0, 0, 0, 0, 1, 0, 0, 0, 0);
        total++;
        if ({bus.branch_o, bus.stall_o, bus.running_o} !== 3'b001 || bus.baddr_o !== 32'h0) begin
            bad++; $display("FAIL after_first: branch/stall/run=%b%b%b baddr=%h want 001 0",
                            bus.branch_o, bus.stall_o, bus.running_o, bus.baddr_o);
        end
        tick();
        $display("test_first_fetch checked");
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            set_in(0, 0, 0, (i < 3), (i >= 3) ? 1'b0 : 1'b1, 0, 0, 0, 0);
            total++;
            if (bus.stall_o !== 1'b1 || bus.branch_o !== 1'b0) begin
                bad++; $display("FAIL stall%0d: stall=%b branch=%b want 1 0", i, bus.stall_o, bus.branch_o);
            end
            tick();
        end
`ifdef FETCH_CTRL_PERF_EN
        total++;
        if (stall_cnt !== 32'd5 || redir_cnt !== 32'd1) begin
            bad++; $display("FAIL perf_cnt: stall_cnt=%0d redir_cnt=%0d want 5 1", stall_cnt, redir_cnt);
        end
`endif
        $display("test_stall checked");
    endtask

    task automatic test_trap_beats_branch();
        set_in(0, 0, 0, 1, 1, 1, 32'h20, 1, 32'h100);
        total++;
        if ({bus.branch_o, bus.stall_o, bus.flush_o} !== 3'b101 || bus.baddr_o !== 32'h100) begin
            bad++; $display("FAIL trap_vs_br: branch/stall/flush=%b%b%b baddr=%h want 101 100",
                            bus.branch_o, bus.stall_o, bus.flush_o, bus.baddr_o);
        end
        tick();
        set_in(0, 0, 0, 0, 1, 0, 0, 0, 0);
        total++;
        if (bus.branch_o !== 1'b0) begin
            bad++; $display("FAIL br_dropped: branch=%b baddr=%h want 0", bus.branch_o, bus.baddr_o);
        end
        tick();
        $display("test_trap_beats_branch checked");
    endtask

    task automatic test_halt_pending();
        set_in(0, 0, 1, 0, 1, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 1, 1, 32'h20, 0, 0);
        total++;
        if ({bus.stall_o, bus.branch_o, bus.running_o} !== 3'b100) begin
            bad++; $display("FAIL halt_state: stall/branch/run=%b%b%b want 100",
                            bus.stall_o, bus.branch_o, bus.running_o);
        end
        tick();
        set_in(0, 0, 0, 0, 1, 0, 0, 1, 32'h100);
        tick();
        set_in(0, 0, 0, 0, 1, 1, 32'h30, 0, 0);
        tick();
        set_in(0, 1, 0, 0, 1, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 1, 0, 0, 0, 0);
        total++;
        if ({bus.branch_o, bus.flush_o} !== 2'b11 || bus.baddr_o !== 32'h100) begin
            bad++; $display("FAIL resume_trap: branch/flush=%b%b baddr=%h want 11 100",
                            bus.branch_o, bus.flush_o, bus.baddr_o);
        end
        tick();
        set_in(0, 0, 0, 0, 1, 0, 0, 0, 0);
        total++;
        if (bus.branch_o !== 1'b0 || bus.stall_o !== 1'b0) begin
            bad++; $display("FAIL pend_cleared: branch=%b stall=%b baddr=%h want 0 0",
                            bus.branch_o, bus.stall_o, bus.baddr_o);
        end
        tick();
        $display("test_halt_pending checked");
    endtask

    task automatic test_halt_with_branch();
        set_in(0, 0, 1, 0, 1, 1, 32'h80, 0, 0);
        total++;
        if ({bus.branch_o, bus.stall_o} !== 2'b10 || bus.baddr_o !== 32'h80) begin
            bad++; $display("FAIL halt_br: branch/stall=%b%b baddr=%h want 10 80",
                            bus.branch_o, bus.stall_o, bus.baddr_o);
        end
        tick();
        set_in(0, 0, 0, 0, 1, 0, 0, 0, 0);
        total++;
        if ({bus.stall_o, bus.running_o, bus.branch_o} !== 3'b100) begin
            bad++; $display("FAIL halt_after_br: stall/run/branch=%b%b%b want 100",
                            bus.stall_o, bus.running_o, bus.branch_o);
        end
        $display("test_halt_with_branch checked");
    endtask

    task automatic test_reset_discard();
        set_in(0, 0, 0, 0, 1, 0, 0, 1, 32'h100);
        tick();
        set_in(1, 0, 0, 0, 1, 0, 0, 0, 0);
        tick();
        set_in(0, 1, 0, 0, 1, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 1, 0, 0, 0, 0);
        total++;
        if (bus.branch_o !== 1'b1 || bus.baddr_o !== RV) begin
            bad++; $display("FAIL rst_discard: branch=%b baddr=%h want 1 %h", bus.branch_o, bus.baddr_o, RV);
        end
        tick();
        set_in(0, 0, 0, 0, 1, 0, 0, 0, 0);
        total++;
        if (bus.branch_o !== 1'b0) begin
            bad++; $display("FAIL rst_no_trap: branch=%b baddr=%h want 0", bus.branch_o, bus.baddr_o);
        end
        tick();
        $display("test_reset_discard checked");
    endtask

    task automatic test_random();
        int errs_before;
        errs_before = bad;
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(59) == 0), ($urandom_range(7) == 0), ($urandom_range(9) == 0),
                   ($urandom_range(2) == 0), ($urandom_range(3) != 0),
                   ($urandom_range(3) == 0), ($urandom & 32'hFFFC),
                   ($urandom_range(9) == 0), ($urandom & 32'hFFFC));
            model_out();
            if (!rst || m_mode != 0 || i > 0) begin
                total++;
                if ({bus.stall_o, bus.branch_o, bus.flush_o, bus.running_o} !== {e_stall, e_branch, e_flush, e_run}
                    || bus.baddr_o !== e_addr) begin
                    bad++;
                    $display("FAIL rand%0d: stall/branch/flush/run=%b%b%b%b baddr=%h want %b%b%b%b baddr=%h", i,
                             bus.stall_o, bus.branch_o, bus.flush_o, bus.running_o, bus.baddr_o,
                             e_stall, e_branch, e_flush, e_run, e_addr);
                end
            end
            tick();
        end
`ifdef FETCH_CTRL_PERF_EN
        total++;
        if (stall_cnt !== m_scnt || redir_cnt !== m_rcnt) begin
            bad++; $display("FAIL rand_perf: stall_cnt=%0d redir_cnt=%0d want %0d %0d",
                            stall_cnt, redir_cnt, m_scnt, m_rcnt);
        end
`endif
        $display("test_random: 400 cycles, %0d new errors", bad - errs_before);
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_trap_beats_branch();
        test_halt_pending();
        test_halt_with_branch();
        test_reset_discard();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
